fu_alu_arbiter: RTL

- Shares one registered two-input ALU function cell among NREQ requesters.
- The ALU computes add, sub, pass-in0 or pass-in1, selected by a 2-bit config and registered on clk.
- The block arbitrates requests round-robin and drives the ALU config and operands.
- It waits out the ALU's one-cycle register latency, then returns the result with a requester ID over a valid/ready response channel.
- It sits between PE-level request sources and a single fu_alu0_2_1 instance.

---
 rtl/fu_alu_pkg.sv | 22 ++
 rtl/rr_pick.sv | 31 +++
 rtl/fu_alu_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fu_alu_pkg.sv
// Shared types and constants for the shared-ALU arbiter.
package fu_alu_pkg;

  localparam int unsigned ALU_CFG_W = 2;

  // ALU function select, forwarded unmodified as config_sig.
  typedef enum logic [ALU_CFG_W-1:0] {
    OP_ADD   = 2'd0,
    OP_SUB   = 2'd1,
    OP_PASS0 = 2'd2,
    OP_PASS1 = 2'd3
  } op_e;

  // Arbiter sequence: accept, wait for the ALU register, capture, hand off.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any_valid
);

  logic [31:0] j;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    j         = '0;
    for (int unsigned off = 0; off < N; off++) begin
      j = (32'(ptr) + off) % N;
      if (!any_valid && valid[j]) begin
        any_valid = 1'b1;
        grant[j]  = 1'b1;
        idx       = j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fu_alu_arbiter.sv
// Round-robin arbiter sharing one registered two-input ALU among NREQ requesters.
module fu_alu_arbiter
  import fu_alu_pkg::*;
#(
  parameter int unsigned size = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [ALU_CFG_W*NREQ-1:0] req_op,
  input  logic [size*NREQ-1:0]      req_in0,
  input  logic [size*NREQ-1:0]      req_in1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [IDW-1:0]            resp_id,
  output logic [size-1:0]           resp_data,
  output logic [ALU_CFG_W-1:0]      alu_config_sig,
  output logic [size-1:0]           alu_in0,
  output logic [size-1:0]           alu_in1,
  input  logic [size-1:0]           alu_out0,
  output logic                      busy
);

  state_e                 state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ALU_CFG_W-1:0]   cfg_q, cfg_d;
  logic [size-1:0]        in0_q, in0_d;
  logic [size-1:0]        in1_q, in1_d;
  logic [size-1:0]        data_q, data_d;
  logic [IDW-1:0]         id_q, id_d;
  logic                   valid_q, valid_d;

  logic [NREQ-1:0]        grant;
  logic [IDW-1:0]         grant_idx;
  logic                   any_valid;

  rr_pick #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .idx       (grant_idx),
    .any_valid (any_valid)
  );

  // Next-state and operand latching; everything holds unless the state says otherwise.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cfg_d    = cfg_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    data_d   = data_q;
    id_d     = id_q;
    valid_d  = valid_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          cfg_d   = req_op[ALU_CFG_W*32'(grant_idx) +: ALU_CFG_W];
          in0_d   = req_in0[size*32'(grant_idx) +: size];
          in1_d   = req_in1[size*32'(grant_idx) +: size];
          id_d    = grant_idx;
          state_d = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        // Only here is alu_out0 trusted; the ALU itself has no reset.
        data_d  = alu_out0;
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          valid_d  = 1'b0;
          rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cfg_q    <= '0;
      in0_q    <= '0;
      in1_q    <= '0;
      data_q   <= '0;
      id_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cfg_q    <= cfg_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      data_q   <= data_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
    end
  end

  // Grants are only offered while idle.
  always_comb begin
    req_ready      = (state_q == IDLE) ? grant : '0;
    busy           = (state_q != IDLE);
    alu_config_sig = cfg_q;
    alu_in0        = in0_q;
    alu_in1        = in1_q;
    resp_data      = data_q;
    resp_id        = id_q;
    resp_valid     = valid_q;
  end

endmodule
